tetris_input_ctrl: RTL and testbench
====================================

TETRIS_INPUT_CTRL -- requirements
Module: tetris_input_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 1000000, number of stable cycles needed to accept a button change.
REQ-002 Parameter REPEAT_DELAY, default 30000000, hold cycles before auto-repeat starts.
REQ-003 Parameter REPEAT_RATE, default 8000000, cycles between auto-repeat events.
REQ-004 Parameters GRAVITY_BASE / GRAVITY_STEP / GRAVITY_MIN, defaults 100000000 / 6000000 / 5000000, gravity period controls.
REQ-005 clk  input  1  single system clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 btn  input  6  raw asynchronous buttons: [0] left, [1] right, [2] rotate, [3] soft drop, [4] hard drop, [5] hold.
REQ-008 level  input  4  game level, used for the gravity period.
REQ-009 ctrl_ready  input  1  tetris core accepts ctrl this cycle.
REQ-010 ctrl  output  3  command to the tetris core: 0 none, 1 left, 2 right, 3 rotate, 4 soft drop, 5 hard drop, 6 hold, 7 gravity.

Function
REQ-011 Each btn bit SHALL pass a 2-flop synchronizer, then a debouncer; debounced state flips only after the synchronized value differs from it for DEBOUNCE_CYC consecutive cycles.
REQ-012 A debounced 0->1 transition SHALL set that button's pending bit on the same edge the debounced state flips.
REQ-013 Gravity counter SHALL increment each cycle; period = max(GRAVITY_BASE - level*GRAVITY_STEP, GRAVITY_MIN); when counter >= period-1, it SHALL clear and set the gravity pending bit.
REQ-014 A level change mid-count SHALL take effect immediately; a counter already >= new period-1 ticks on the next edge.
REQ-015 Acceptance of soft drop or hard drop SHALL restart the gravity counter at 0.
REQ-016 Pending bits SHALL coalesce: an event arriving while its bit is already set is dropped.
REQ-017 Handshake: acceptance occurs on an edge where ctrl != 0 and ctrl_ready = 1; ctrl SHALL hold stable until accepted.
REQ-018 When ctrl = 0, or on an accepting edge, ctrl SHALL load the highest-priority pending event, excluding the event being accepted. Only pending bits set before that edge are considered.
REQ-019 Priority, highest first: hard drop, hold, rotate, left, right, soft drop, gravity.
REQ-020 An accepted event's pending bit SHALL clear on the accepting edge unless a new instance is set on that same edge; in that case it stays set.
REQ-021 Latency: button edge into an idle block -> pending set at edge N -> ctrl valid after edge N+1.
REQ-022 Left and right pressed together SHALL both be delivered, left first.

Reset
REQ-023 reset SHALL clear synchronizers, debounced states (to 0), pending bits, repeat counters and the gravity counter.
REQ-024 ctrl SHALL be 0 during reset and on the first edge after reset; a reset mid-handshake SHALL discard the presented command.
REQ-025 A button held through reset SHALL produce one press event after DEBOUNCE_CYC cycles.

Configuration
REQ-026 With TETRIS_AUTO_REPEAT_EN defined: a held left, right or soft drop SHALL set its pending bit again after REPEAT_DELAY cycles of debounced hold, then every REPEAT_RATE cycles. The counter restarts on release.
REQ-027 Without TETRIS_AUTO_REPEAT_EN: only press edges generate events, and the repeat counters are not built.

Structure
REQ-028 Package tetris_pkg SHALL hold the ctrl encoding enum, the button index constants and the priority order.
REQ-029 Sub-module tetris_debounce (synchronizer plus debounce counter, one bit) SHALL be instantiated six times.

Verification
Sim parameters: DEBOUNCE_CYC=4, REPEAT_DELAY=10, REPEAT_RATE=3, GRAVITY_BASE=20, GRAVITY_STEP=2, GRAVITY_MIN=4.
REQ-030 Bounce: btn[0] toggles 1,0,1 with gaps of 2 cycles, then holds high, ctrl_ready=1 -> exactly one ctrl=1 pulse.
REQ-031 Gravity: level=0, ctrl_ready=1, no buttons -> ctrl=7 once every 20 cycles. level=9 -> period 4 (clamped from 2).
REQ-032 Backpressure: ctrl_ready=0, press rotate then hard drop -> ctrl=3 held. Raise ready -> accept 3, then next value 5. Second rotate press while pending is dropped.
REQ-033 Simultaneous: left and right on the same cycle, ready=1 -> ctrl 1 then 2 on consecutive accepts.
REQ-034 Auto-repeat (macro on): hold btn[1] for 30 cycles after debounce -> ctrl=2 at the press, then after 10 cycles, then every 3 cycles. Macro off -> single event only.
REQ-035 Reset mid-handshake: ctrl=6 presented with ready=0, assert reset for 1 cycle -> ctrl=0 and no hold command delivered afterwards.

Source files
------------

// File: rtl/tetris_pkg.sv
// tetris_pkg: command encoding, button indices and event priority shared by the input controller.
// Latency: none (types, constants and a pure selection function).
// Backpressure: none.
package tetris_pkg;

    // Commands presented to the tetris core. Button bit b maps to command b+1.
    typedef enum logic [2:0] {
        CTRL_NONE    = 3'd0,
        CTRL_LEFT    = 3'd1,
        CTRL_RIGHT   = 3'd2,
        CTRL_ROTATE  = 3'd3,
        CTRL_SOFT    = 3'd4,
        CTRL_HARD    = 3'd5,
        CTRL_HOLD    = 3'd6,
        CTRL_GRAVITY = 3'd7
    } ctrl_e;

    localparam int NUM_BTN    = 6;
    localparam int NUM_EVT    = 7;

    localparam int BTN_LEFT   = 0;
    localparam int BTN_RIGHT  = 1;
    localparam int BTN_ROTATE = 2;
    localparam int BTN_SOFT   = 3;
    localparam int BTN_HARD   = 4;
    localparam int BTN_HOLD   = 5;

    // Buttons that auto-repeat while held (only used when auto-repeat is built).
    localparam logic [NUM_BTN-1:0] RPT_MASK = (6'd1 << BTN_LEFT) | (6'd1 << BTN_RIGHT) | (6'd1 << BTN_SOFT);

    // Delivery order, highest priority first.
    localparam ctrl_e PRIO [NUM_EVT] = '{CTRL_HARD, CTRL_HOLD, CTRL_ROTATE, CTRL_LEFT,
                                         CTRL_RIGHT, CTRL_SOFT, CTRL_GRAVITY};

    // Highest-priority command whose pending bit is set; CTRL_NONE if none.
    function automatic ctrl_e pick_event(input logic [7:1] avail);
        ctrl_e sel;
        sel = CTRL_NONE;
        for (int i = NUM_EVT - 1; i >= 0; i--) begin
            if (avail[PRIO[i]]) begin
                sel = PRIO[i];
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/tetris_debounce.sv
// tetris_debounce: 2-flop synchronizer plus stable-run debouncer for one raw button.
// Latency: raw change reaches state after 2 sync edges plus DEBOUNCE_CYC stable cycles.
// Backpressure: none; flip is a combinational strobe valid on the edge state changes.
module tetris_debounce #(
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic state,
    output logic flip
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] cnt;

    // The edge on which state takes the synchronized value.
    assign flip = (sync_q2 != state) && (cnt == CNT_W'(DEBOUNCE_CYC - 1));

    // Synchronize, then count consecutive cycles of disagreement before accepting the new level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            state   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
            if (sync_q2 == state) begin
                cnt <= '0;
            end else if (flip) begin
                state <= sync_q2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tetris_input_ctrl.sv
// tetris_input_ctrl: debounced buttons and a level-scaled gravity timer -> one command at a time to the core.
// Latency: debounced press sets pending on edge N, ctrl presents it after edge N+1.
// Backpressure: ctrl holds until ctrl_ready; repeat events coalesce in pending bits. Auto-repeat: TETRIS_AUTO_REPEAT_EN.
module tetris_input_ctrl
    import tetris_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int REPEAT_DELAY = 30000000,
    parameter int REPEAT_RATE  = 8000000,
    parameter int GRAVITY_BASE = 100000000,
    parameter int GRAVITY_STEP = 6000000,
    parameter int GRAVITY_MIN  = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] btn,
    input  logic [3:0] level,
    input  logic       ctrl_ready,
    output logic [2:0] ctrl
);
    logic [NUM_BTN-1:0] db_state;
    logic [NUM_BTN-1:0] db_flip;
    logic [NUM_BTN-1:0] db_rise;
    logic [NUM_BTN-1:0] rpt_evt;
    logic [NUM_BTN-1:0] btn_evt;
    logic [31:0]        grav_cnt;
    logic [31:0]        grav_period;
    logic [31:0]        step_total;
    logic               grav_tick;
    logic               accept;
    logic               drop_acc;
    logic [7:1]         acc_mask;
    logic [7:1]         set_mask;
    logic [7:1]         pend;

    // A zero timing parameter would leave a counter compare that never matches.
    if (DEBOUNCE_CYC < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1 || GRAVITY_MIN < 1) begin : g_bad_cfg
        $error("tetris_input_ctrl: timing parameters must be >= 1");
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        tetris_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_debounce (
            .clk    (clk),
            .reset  (reset),
            .btn_raw(btn[g]),
            .state  (db_state[g]),
            .flip   (db_flip[g])
        );
    end

    // A press is a flip while the debounced state is still low.
    assign db_rise = db_flip & ~db_state;

`ifdef TETRIS_AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_rpt
        if (RPT_MASK[g]) begin : g_on
            logic [RPT_W-1:0] cnt;
            logic             in_rate;
            logic             held;

            // Held means debounced high and not releasing on this edge.
            assign held       = db_state[g] && !db_flip[g];
            assign rpt_evt[g] = held && (cnt == (in_rate ? RPT_W'(REPEAT_RATE - 1)
                                                         : RPT_W'(REPEAT_DELAY - 1)));

            // Initial delay phase, then fixed-rate phase; any release starts over.
            always_ff @(posedge clk) begin
                if (reset || !held) begin
                    cnt     <= '0;
                    in_rate <= 1'b0;
                end else if (rpt_evt[g]) begin
                    cnt     <= '0;
                    in_rate <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end else begin : g_off
            assign rpt_evt[g] = 1'b0;
        end
    end
`else
    assign rpt_evt = '0;
`endif

    assign btn_evt = db_rise | rpt_evt;

    // Gravity period shrinks with level and is floored at GRAVITY_MIN; level is used live.
    always_comb begin
        step_total = 32'(level) * 32'(GRAVITY_STEP);
        if (step_total + 32'(GRAVITY_MIN) >= 32'(GRAVITY_BASE)) begin
            grav_period = 32'(GRAVITY_MIN);
        end else begin
            grav_period = 32'(GRAVITY_BASE) - step_total;
        end
    end

    // ">=" so a level increase past the current count ticks on the next edge.
    assign grav_tick = grav_cnt >= grav_period - 32'd1;
    assign accept    = (ctrl != 3'd0) && ctrl_ready;
    assign drop_acc  = accept && (ctrl == CTRL_SOFT || ctrl == CTRL_HARD);
    // Pending bit k belongs to command k, so the accepted one is a shift of ctrl.
    assign acc_mask  = 7'(accept) << (ctrl - 3'd1);
    assign set_mask  = {grav_tick, btn_evt};

    // Gravity timer: free-running, restarted by its own tick or an accepted drop.
    always_ff @(posedge clk) begin
        if (reset || grav_tick || drop_acc) begin
            grav_cnt <= '0;
        end else begin
            grav_cnt <= grav_cnt + 32'd1;
        end
    end

    // Pending bits and command register: new events win over the clear of an accepted bit,
    // and the reload only sees bits set before this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend <= '0;
            ctrl <= CTRL_NONE;
        end else begin
            pend <= (pend & ~acc_mask) | set_mask;
            if (ctrl == 3'd0 || accept) begin
                ctrl <= pick_event(pend & ~acc_mask);
            end
        end
    end

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// tb_tetris_input_ctrl: directed scenarios plus random button traffic, checked by a scoreboard.
// Latency: expected accepts are queued one edge ahead of the edge that accepts them.
// Backpressure: ctrl_ready is driven both as fixed levels and randomly.
module tb_tetris_input_ctrl;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RR = 3;
    localparam int GB = 20;
    localparam int GS = 2;
    localparam int GM = 4;
    localparam int PRIO [7] = '{5, 6, 3, 1, 2, 4, 7};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] btn = '0;
    logic [3:0] level = '0;
    logic       ctrl_ready = 1'b0;
    logic [2:0] ctrl;

    tetris_input_ctrl #(
        .DEBOUNCE_CYC(DB),
        .REPEAT_DELAY(RD),
        .REPEAT_RATE (RR),
        .GRAVITY_BASE(GB),
        .GRAVITY_STEP(GS),
        .GRAVITY_MIN (GM)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn       (btn),
        .level     (level),
        .ctrl_ready(ctrl_ready),
        .ctrl      (ctrl)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int unsigned cyc;
        int          code;
    } exp_t;
    exp_t sb_q[$];

    // Reference model: raw samples travel a 2-deep queue, then a stable-run debounce,
    // pending events as a set, delivery by priority list.
    logic [5:0] raw_q[$] = '{6'd0, 6'd0};
    bit         m_db  [6];
    int         m_run [6];
`ifdef TETRIS_AUTO_REPEAT_EN
    int         m_age [6];
`endif
    bit         m_pend [1:7];
    int         m_ctrl = 0;
    int         m_since = 0;

    task automatic model_edge(input logic [5:0] b, input logic [3:0] lv, input logic rdy, input logic rst);
        logic [5:0] seen;
        bit         set_ev [1:7];
        bit         was;
        int         period;
        bit         tick;
        bit         acc;
        bit         found;
        if (rst) begin
            raw_q = '{6'd0, 6'd0};
            for (int i = 0; i < 6; i++) begin
                m_db[i]  = 1'b0;
                m_run[i] = 0;
`ifdef TETRIS_AUTO_REPEAT_EN
                m_age[i] = 0;
`endif
            end
            for (int k = 1; k <= 7; k++) m_pend[k] = 1'b0;
            m_ctrl  = 0;
            m_since = 0;
            return;
        end
        for (int k = 1; k <= 7; k++) set_ev[k] = 1'b0;
        seen = raw_q.pop_front();
        raw_q.push_back(b);
        for (int i = 0; i < 6; i++) begin
            was = m_db[i];
            if (seen[i] != m_db[i]) begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    m_db[i]  = seen[i];
                    m_run[i] = 0;
                    if (seen[i]) set_ev[i+1] = 1'b1;
                end
            end else begin
                m_run[i] = 0;
            end
`ifdef TETRIS_AUTO_REPEAT_EN
            if (i == 0 || i == 1 || i == 3) begin
                if (was && m_db[i]) begin
                    m_age[i]++;
                    if (m_age[i] >= RD && (m_age[i] - RD) % RR == 0) set_ev[i+1] = 1'b1;
                end else begin
                    m_age[i] = 0;
                end
            end
`else
            if (was && !m_db[i]) m_run[i] = 0;
`endif
        end
        period = GB - int'(lv) * GS;
        if (period < GM) period = GM;
        tick = (m_since >= period - 1);
        if (tick) set_ev[7] = 1'b1;
        acc = (m_ctrl != 0) && rdy;
        m_since = (tick || (acc && (m_ctrl == 4 || m_ctrl == 5))) ? 0 : m_since + 1;
        if (acc) m_pend[m_ctrl] = 1'b0;
        if (m_ctrl == 0 || acc) begin
            m_ctrl = 0;
            found  = 1'b0;
            for (int p = 0; p < 7; p++) begin
                if (!found && m_pend[PRIO[p]]) begin
                    m_ctrl = PRIO[p];
                    found  = 1'b1;
                end
            end
        end
        for (int k = 1; k <= 7; k++) if (set_ev[k]) m_pend[k] = 1'b1;
    endtask

    // Driver: apply inputs, queue the accept the model predicts for the coming edge, advance the model.
    task automatic step(input logic [5:0] b, input logic [3:0] lv, input logic rdy, input logic rst);
        exp_t e;
        btn        = b;
        level      = lv;
        ctrl_ready = rdy;
        reset      = rst;
        if (!rst && rdy && m_ctrl != 0) begin
            e.cyc  = cyc;
            e.code = m_ctrl;
            sb_q.push_back(e);
        end
        @(posedge clk);
        model_edge(b, lv, rdy, rst);
        #1;
    endtask

    task automatic run(input int n, input logic [5:0] b, input logic [3:0] lv, input logic rdy);
        for (int i = 0; i < n; i++) step(b, lv, rdy, 1'b0);
    endtask

    // Monitor: on every DUT accept, pop and compare; ctrl must be 0 in reset and on the first edge after.
    bit r1 = 1'b1;
    bit r2 = 1'b1;
    always @(negedge clk) begin
        exp_t e;
        if (r1 || r2) begin
            vectors++;
            if (ctrl !== 3'd0) begin
                miscompares++;
                $display("FAIL reset_ctrl cyc=%0d ctrl=%0d required=0", cyc, ctrl);
            end
        end
        if (!reset && ctrl_ready && ctrl !== 3'd0) begin
            vectors++;
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_accept cyc=%0d ctrl=%0d required=none", cyc, ctrl);
            end else begin
                e = sb_q.pop_front();
                if (e.code != int'(ctrl) || e.cyc != cyc) begin
                    miscompares++;
                    $display("FAIL accept cyc=%0d ctrl=%0d required cyc=%0d ctrl=%0d", cyc, ctrl, e.cyc, e.code);
                end
            end
        end
        r2 = r1;
        r1 = reset;
    end

    int         hold_left [6];
    logic [5:0] rb = '0;
    logic [3:0] rl = '0;

    initial begin
        for (int i = 0; i < 3; i++) step(6'd0, 4'd0, 1'b1, 1'b1);
        // bounce on left, then a clean hold
        run(2, 6'b000001, 4'd0, 1'b1);
        run(2, 6'b000000, 4'd0, 1'b1);
        run(2, 6'b000001, 4'd0, 1'b1);
        run(14, 6'b000001, 4'd0, 1'b1);
        run(12, 6'b000000, 4'd0, 1'b1);
        // gravity at level 0 and clamped at level 9
        run(45, 6'b000000, 4'd0, 1'b1);
        run(20, 6'b000000, 4'd9, 1'b1);
        // backpressure: rotate, hard drop, second rotate while pending
        run(8, 6'b000100, 4'd0, 1'b0);
        run(8, 6'b000000, 4'd0, 1'b0);
        run(8, 6'b010000, 4'd0, 1'b0);
        run(8, 6'b000000, 4'd0, 1'b0);
        run(8, 6'b000100, 4'd0, 1'b0);
        run(8, 6'b000000, 4'd0, 1'b0);
        run(12, 6'b000000, 4'd0, 1'b1);
        // left and right together
        run(8, 6'b000011, 4'd0, 1'b1);
        run(12, 6'b000000, 4'd0, 1'b1);
        // hold presented, then reset mid-handshake
        run(8, 6'b100000, 4'd0, 1'b0);
        run(4, 6'b000000, 4'd0, 1'b0);
        step(6'b000000, 4'd0, 1'b0, 1'b1);
        run(20, 6'b000000, 4'd0, 1'b1);
        // rotate held through reset
        run(4, 6'b000100, 4'd0, 1'b1);
        step(6'b000100, 4'd0, 1'b1, 1'b1);
        step(6'b000100, 4'd0, 1'b1, 1'b1);
        run(12, 6'b000100, 4'd0, 1'b1);
        run(10, 6'b000000, 4'd0, 1'b1);
        // right held long enough to auto-repeat when built
        run(45, 6'b000010, 4'd0, 1'b1);
        run(10, 6'b000000, 4'd0, 1'b1);
        // random traffic
        for (int i = 0; i < 6; i++) hold_left[i] = 1;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 6; i++) begin
                if (hold_left[i] == 0) begin
                    rb[i] = ~rb[i];
                    hold_left[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                               : int'($urandom_range(5, 30));
                end
                hold_left[i]--;
            end
            if ($urandom_range(0, 199) == 0) rl = 4'($urandom_range(0, 15));
            step(rb, rl, $urandom_range(0, 3) != 0, $urandom_range(0, 399) == 0);
        end
        run(30, 6'b000000, 4'd0, 1'b1);
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_accepts outstanding=%0d required=0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
